audio_dac: RTL and testbench

Parametrised multi-channel audio DAC for the console core.
- Accepts signed PCM sample frames over a valid/ready handshake.
- Applies per-frame attenuation and mute.
- Drives one 1-bit output per channel, either PWM or first-order sigma-delta.
- Sits between the core's left/right sample outputs and the board audio pins; replaces the fixed-width per-pin PWM instances.

---
 rtl/audio_dac_pkg.sv | 32 +++
 rtl/audio_dac_if.sv | 14 +
 rtl/audio_dac_chan.sv | 52 +++++
 rtl/audio_dac.sv | 130 +++++++++++++
 tb/tb_audio_dac.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/audio_dac_pkg.sv
// Shared constants and conversion helpers for the audio DAC slice.
// Used by audio_dac and audio_dac_chan; LFSR items matter only with AUDIO_DAC_DITHER_EN.
package audio_pkg;

   localparam int MODE_PWM = 0;
   localparam int MODE_SDM = 1;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting form of taps 16,14,13,11 (bit positions 0,2,3,5).
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] midscale(input int width);
      return 16'd1 << (width - 1);
   endfunction

   // Attenuate, move to offset binary, keep the top `width` bits of the sample.
   function automatic logic [15:0] to_duty(input logic signed [31:0] sample,
                                           input logic [2:0]         shift,
                                           input int                 in_width,
                                           input int                 width);
      logic signed [31:0] att;
      logic [31:0]        ofs;
      att = sample >>> shift;
      ofs = att + (32'd1 << (in_width - 1));
      return 16'(ofs >> (in_width - width));
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {^(l & LFSR_TAPS), l[15:1]};
   endfunction

endpackage

// File: rtl/audio_dac_if.sv
// Sample-frame stream into the audio DAC: valid/ready plus per-frame volume and mute.
interface audio_dac_if #(
   parameter int CHANNELS = 2,
   parameter int IN_WIDTH = 16
);
   logic                         s_valid;
   logic                         s_ready;
   logic [CHANNELS*IN_WIDTH-1:0] s_data;
   logic [2:0]                   vol_shift;
   logic                         mute;

   modport master (output s_valid, s_data, vol_shift, mute, input s_ready);
   modport slave  (input s_valid, s_data, vol_shift, mute, output s_ready);
endinterface

// File: rtl/audio_dac_chan.sv
// One DAC channel: active duty register feeding a PWM comparator or first-order sigma-delta.
module audio_dac_chan
   import audio_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int MODE  = MODE_PWM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt,
   input  logic             load,
   input  logic [WIDTH-1:0] load_duty,
   output logic             out
);
   localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

   logic [WIDTH-1:0] duty_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH:0]   sum_s;
   logic             out_nxt_s;
   logic             out_r;

   assign sum_s = {1'b0, acc_r} + {1'b0, duty_r};

   // Carry of the accumulator add is exactly the registered sigma-delta bit.
   always_comb begin
      out_nxt_s = 1'b0;
      if (MODE == MODE_SDM) begin
         out_nxt_s = sum_s[WIDTH];
      end else begin
         out_nxt_s = (cnt < duty_r);
      end
   end

   // Duty, accumulator and output bit state.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_r <= MID;
         acc_r  <= '0;
         out_r  <= 1'b0;
      end else begin
         out_r <= out_nxt_s;
         acc_r <= sum_s[WIDTH-1:0];
         if (load) begin
            duty_r <= load_duty;
         end
      end
   end

   assign out = out_r;

endmodule

// File: rtl/audio_dac.sv
// Multi-channel audio DAC top: period counter, one-frame pending buffer, underrun flag.
// Optional dither on each frame load when AUDIO_DAC_DITHER_EN is defined.
module audio_dac
   import audio_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int IN_WIDTH = 16,
   parameter int WIDTH    = 9,
   parameter int MODE     = MODE_PWM
) (
   input  logic                clk,
   input  logic                rst,
   audio_dac_if.slave          s,
   output logic [CHANNELS-1:0] out,
   output logic                frame_tick,
   output logic                underrun
);
   localparam logic [WIDTH-1:0] MID = WIDTH'(midscale(WIDTH));

   logic [WIDTH-1:0] cnt_r;
   logic             wrap_s;
   logic             accept_s;
   logic             load_s;
   logic             pend_full_r;
   logic             underrun_r;
   logic             frame_tick_r;
   logic [WIDTH-1:0] conv_s      [CHANNELS];
   logic [WIDTH-1:0] pend_duty_r [CHANNELS];
   logic [WIDTH-1:0] load_duty_s [CHANNELS];

   assign wrap_s    = (cnt_r == {WIDTH{1'b1}});
   assign s.s_ready = !pend_full_r && !rst;
   assign accept_s  = s.s_valid && s.s_ready;
   assign load_s    = wrap_s && pend_full_r;

   // Frames are converted at accept time with that cycle's volume and mute.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         conv_s[c] = MID;
         if (s.mute) begin
            conv_s[c] = MID;
         end else begin
            conv_s[c] = WIDTH'(to_duty(32'($signed(s.s_data[c*IN_WIDTH +: IN_WIDTH])),
                                       s.vol_shift, IN_WIDTH, WIDTH));
         end
      end
   end

   // Period counter, pending buffer and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r        <= '0;
         pend_full_r  <= 1'b0;
         underrun_r   <= 1'b0;
         frame_tick_r <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            pend_duty_r[c] <= '0;
         end
      end else begin
         cnt_r        <= cnt_r + WIDTH'(1'b1);
         frame_tick_r <= wrap_s;
         if (accept_s) begin
            pend_full_r <= 1'b1;
            pend_duty_r <= conv_s;
         end else if (load_s) begin
            pend_full_r <= 1'b0;
         end
         if (wrap_s && !pend_full_r) begin
            underrun_r <= 1'b1;
         end
      end
   end

`ifdef AUDIO_DAC_DITHER_EN
   logic [15:0] lfsr_r;
   logic        pend_mute_r;

   // LFSR steps once per period; mute is remembered so muted frames stay exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r      <= LFSR_SEED;
         pend_mute_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
         end
         if (accept_s) begin
            pend_mute_r <= s.mute;
         end
      end
   end

   // Add one LSB of dither, saturating at full scale.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         load_duty_s[c] = pend_duty_r[c];
         if (pend_mute_r || !lfsr_r[0] || (&pend_duty_r[c])) begin
            load_duty_s[c] = pend_duty_r[c];
         end else begin
            load_duty_s[c] = pend_duty_r[c] + WIDTH'(1'b1);
         end
      end
   end
`else
   // Without dither the pending duty loads unchanged.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         load_duty_s[c] = pend_duty_r[c];
      end
   end
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      audio_dac_chan #(
         .WIDTH (WIDTH),
         .MODE  (MODE)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .cnt       (cnt_r),
         .load      (load_s),
         .load_duty (load_duty_s[c]),
         .out       (out[c])
      );
   end

   assign frame_tick = frame_tick_r;
   assign underrun   = underrun_r;

endmodule

// File: tb/tb_audio_dac.sv
// Bench for audio_dac: PWM and sigma-delta instances share stimulus; ones per period are
// compared with the duty a frame-level model expects for that period.
module tb_audio_dac;
   localparam int CH = 2;
   localparam int IW = 16;
   localparam int W  = 9;
   localparam int P  = 1 << W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   audio_dac_if #(.CHANNELS(CH), .IN_WIDTH(IW)) bus_p ();
   audio_dac_if #(.CHANNELS(CH), .IN_WIDTH(IW)) bus_s ();

   logic [CH-1:0] out_p, out_s;
   logic          tick_p, tick_s, und_p, und_s;

   audio_dac #(.CHANNELS(CH), .IN_WIDTH(IW), .WIDTH(W), .MODE(0)) dut_pwm (
      .clk(clk), .rst(rst), .s(bus_p), .out(out_p), .frame_tick(tick_p), .underrun(und_p));
   audio_dac #(.CHANNELS(CH), .IN_WIDTH(IW), .WIDTH(W), .MODE(1)) dut_sdm (
      .clk(clk), .rst(rst), .s(bus_s), .out(out_s), .frame_tick(tick_s), .underrun(und_s));

   int n_cmp = 0;
   int n_mis = 0;

   int pend0[$];
   int pend1[$];
   int act0, act1, per0, per1;
   bit m_und;
   int e;
   int ones_p0, ones_p1, ones_s0, ones_s1;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
      end
   endtask

   function automatic int ref_duty(input logic [15:0] x, input int sh, input bit m);
      int sx;
      if (m) return P / 2;
      sx = int'($signed(x));
      return ((sx >>> sh) + 32768) / (65536 / P);
   endfunction

   task automatic drive(input bit v, input logic [31:0] d, input logic [2:0] sh, input bit m);
      bus_p.s_valid = v; bus_p.s_data = d; bus_p.vol_shift = sh; bus_p.mute = m;
      bus_s.s_valid = v; bus_s.s_data = d; bus_s.vol_shift = sh; bus_s.mute = m;
   endtask

   task automatic model_reset();
      pend0.delete(); pend1.delete();
      act0 = P / 2; act1 = P / 2; per0 = P / 2; per1 = P / 2;
      m_und = 1'b0; e = 0;
      ones_p0 = 0; ones_p1 = 0; ones_s0 = 0; ones_s1 = 0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      drive(1'b0, 32'd0, 3'd0, 1'b0);
      @(negedge clk);
      check_eq("rst_out_pwm", int'(out_p), 0);
      check_eq("rst_out_sdm", int'(out_s), 0);
      check_eq("rst_tick", int'(tick_p | tick_s), 0);
      check_eq("rst_underrun", int'(und_p | und_s), 0);
      check_eq("rst_ready", int'(bus_p.s_ready | bus_s.s_ready), 0);
      repeat (n - 1) @(negedge clk);
      model_reset();
      rst = 1'b0;
      #1;
      check_eq("ready_release", int'(bus_p.s_ready & bus_s.s_ready), 1);
   endtask

   // One clock: drive inputs, advance the frame-level model, then check.
   task automatic step(input bit v, input logic [31:0] d, input logic [2:0] sh, input bit m);
      bit acc;
      drive(v, d, sh, m);
      acc = v && (pend0.size() == 0);
      if ((e + 1) % P == 0) begin
         if (pend0.size() > 0) begin
            act0 = pend0.pop_front();
            act1 = pend1.pop_front();
         end else begin
            m_und = 1'b1;
         end
      end
      if (acc) begin
         pend0.push_back(ref_duty(d[15:0], int'(sh), m));
         pend1.push_back(ref_duty(d[31:16], int'(sh), m));
      end
      @(negedge clk);
      e++;
      ones_p0 += int'(out_p[0]); ones_p1 += int'(out_p[1]);
      ones_s0 += int'(out_s[0]); ones_s1 += int'(out_s[1]);
      check_eq("ready_pwm", int'(bus_p.s_ready), int'(pend0.size() == 0));
      check_eq("ready_sdm", int'(bus_s.s_ready), int'(pend0.size() == 0));
      check_eq("tick_pwm", int'(tick_p), int'(e % P == 0));
      check_eq("tick_sdm", int'(tick_s), int'(e % P == 0));
      check_eq("underrun_pwm", int'(und_p), int'(m_und));
      check_eq("underrun_sdm", int'(und_s), int'(m_und));
      if (e % P == 0) begin
         check_eq("ones_pwm_ch0", ones_p0, per0);
         check_eq("ones_pwm_ch1", ones_p1, per1);
         check_eq("ones_sdm_ch0", ones_s0, per0);
         check_eq("ones_sdm_ch1", ones_s1, per1);
         ones_p0 = 0; ones_p1 = 0; ones_s0 = 0; ones_s1 = 0;
         per0 = act0; per1 = act1;
      end
   endtask

   task automatic idle_step();
      step(1'b0, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
   endtask

   task automatic run_to_wrap();
      for (int i = 0; i < P; i++) begin
         idle_step();
         if (e % P == 0) break;
      end
   endtask

   // Hold valid until the frame is taken; a frame never taken counts as a failure.
   task automatic send_frame(input logic [31:0] d, input logic [2:0] sh, input bit m);
      int taken;
      taken = 0;
      for (int i = 0; i < 2 * P; i++) begin
         if (pend0.size() == 0) taken = 1;
         step(1'b1, d, sh, m);
         if (taken == 1) break;
      end
      check_eq("send_accepted", taken, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(3);

      // Idle from reset: midscale everywhere, underrun after the first wrap.
      repeat (P + 10) idle_step();

      // Full-scale positive / negative frame.
      send_frame(32'h8000_7FFF, 3'd0, 1'b0);
      run_to_wrap();
      run_to_wrap();

      // Back-to-back frames: the later ones wait for the wraps.
      send_frame(32'h1234_C000, 3'd0, 1'b0);
      send_frame(32'h6000_A000, 3'd2, 1'b0);
      send_frame(32'hF000_0100, 3'd7, 1'b0);
      run_to_wrap();
      run_to_wrap();
      run_to_wrap();

      // Attenuation and mute.
      send_frame(32'h7FFE_7FFE, 3'd1, 1'b0);
      send_frame(32'h7FFE_7FFE, 3'd1, 1'b1);
      run_to_wrap();
      run_to_wrap();
      run_to_wrap();

      // Fed every period from reset: underrun must stay clear.
      do_reset(2);
      repeat (4) send_frame(32'h4000_4000, 3'd0, 1'b0);
      run_to_wrap();

      // Random traffic.
      for (int i = 0; i < 6 * P; i++) begin
         step(1'($urandom_range(0, 99) < 2), $urandom, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 7) == 0));
      end

      // Reset with a frame pending: it must never reach the outputs.
      run_to_wrap();
      send_frame(32'h7FFF_8000, 3'd0, 1'b0);
      repeat (100) idle_step();
      do_reset(2);
      run_to_wrap();
      run_to_wrap();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
